fft_stage_sequencer: RTL and testbench

- Control end of the radix-2 FFT datapath: schedules every butterfly of an in-place, decimation-in-time FFT over an external sample RAM.
- Issues read addresses for the A/B operand pair and the twiddle index each cycle. Delays those addresses to match the butterfly pipeline, then issues the write-back addresses for the X/Y results.
- The sample RAM (2 read + 2 write ports) and the twiddle ROM sit outside this block. Their read data connects directly to the butterfly. Butterfly outputs connect directly to the RAM write data.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_addr_gen.sv | 28 ++
 rtl/fft_stage_sequencer.sv | 134 +++++++++++++
 tb/tb_fft_stage_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 FFT stage sequencer.
package fft_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam int MEM_LAT_DEF  = 1;
    localparam int BFLY_LAT_DEF = 4;
    localparam int PIPE_LAT     = MEM_LAT_DEF + BFLY_LAT_DEF;

    function automatic int pipe_lat(input int mem_lat, input int bfly_lat);
        return mem_lat + bfly_lat;
    endfunction

    // Butterfly index width: N/2 butterflies per stage.
    function automatic int bidx_w(input int log2n);
        return log2n - 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational (stage, butterfly) -> operand and twiddle address mapping for in-place DIT.
module fft_addr_gen #(
    parameter int LOG2N = 3
) (
    input  logic [LOG2N-1:0] stage_i,
    input  logic [LOG2N-2:0] bfly_i,
    output logic [LOG2N-1:0] addr_a_o,
    output logic [LOG2N-1:0] addr_b_o,
    output logic [LOG2N-2:0] tw_addr_o
);

    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] bx;
    logic [LOG2N-2:0] kmask;
    logic [LOG2N-2:0] k;

    // addr_a is b with a zero bit inserted at position s; addr_b sets that bit.
    always_comb begin
        half      = LOG2N'(1) << stage_i;
        kmask     = (LOG2N-1)'(half - LOG2N'(1));
        k         = bfly_i & kmask;
        bx        = {1'b0, bfly_i};
        addr_a_o  = ((bx >> stage_i) << (stage_i + LOG2N'(1))) | {1'b0, k};
        addr_b_o  = addr_a_o | half;
        tw_addr_o = k << (LOG2N - 1 - int'(stage_i));
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Butterfly scheduler for an in-place radix-2 DIT FFT: read issue, drain, delayed write-back.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N    = 3,
    parameter int MEM_LAT  = MEM_LAT_DEF,
    parameter int BFLY_LAT = BFLY_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_x,
    output logic [LOG2N-1:0] wr_addr_y
);

    localparam int PL = pipe_lat(MEM_LAT, BFLY_LAT);
    localparam int BW = bidx_w(LOG2N);
    localparam int DW = cnt_w(PL);
    localparam logic [BW-1:0]    B_LAST = '1;
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(PL - 1);

    state_t           state_q, state_d;
    logic [LOG2N-1:0] s_q, s_d;
    logic [BW-1:0]    b_q, b_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;

    logic [LOG2N-1:0] ga, gb;
    logic [LOG2N-2:0] gtw;

    logic [PL-1:0]            vld_pipe_q;
    logic [PL-1:0][LOG2N-1:0] a_pipe_q;
    logic [PL-1:0][LOG2N-1:0] b_pipe_q;

    fft_addr_gen #(.LOG2N(LOG2N)) u_agen (
        .stage_i   (s_q),
        .bfly_i    (b_q),
        .addr_a_o  (ga),
        .addr_b_o  (gb),
        .tw_addr_o (gtw)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        dcnt_d  = dcnt_q;
        rd_en   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    s_d     = '0;
                    b_d     = '0;
                end
            end
            ISSUE: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (b_q == B_LAST) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Hold off the next stage until its inputs have been written back.
                if (dcnt_q == D_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        s_d     = s_q + LOG2N'(1);
                        b_d     = '0;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s_q        <= '0;
            b_q        <= '0;
            dcnt_q     <= '0;
            vld_pipe_q <= '0;
            a_pipe_q   <= '0;
            b_pipe_q   <= '0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            b_q           <= b_d;
            dcnt_q        <= dcnt_d;
            vld_pipe_q[0] <= rd_en;
            a_pipe_q[0]   <= rd_addr_a;
            b_pipe_q[0]   <= rd_addr_b;
            for (int i = 1; i < PL; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                a_pipe_q[i]   <= a_pipe_q[i-1];
                b_pipe_q[i]   <= b_pipe_q[i-1];
            end
        end
    end

    // Addresses are forced to zero outside ISSUE so idle pipe slots carry zeros.
    assign rd_addr_a = rd_en ? ga  : '0;
    assign rd_addr_b = rd_en ? gb  : '0;
    assign tw_addr   = rd_en ? gtw : '0;
    assign stage     = s_q;
    assign wr_en     = vld_pipe_q[PL-1];
    assign wr_addr_x = a_pipe_q[PL-1];
    assign wr_addr_y = b_pipe_q[PL-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench: address schedule, timing, restart, reset, and an end-to-end N=8 FFT.
module tb_fft_stage_sequencer;
    import fft_pkg::*;

    localparam int PL  = PIPE_LAT;
    localparam int PL2 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start2;

    logic       busy, done, rd_en, wr_en;
    logic [2:0] stage, rd_addr_a, rd_addr_b, wr_addr_x, wr_addr_y;
    logic [1:0] tw_addr;

    logic       busy2, done2, rd_en2, wr_en2;
    logic [1:0] stage2, rd_addr_a2, rd_addr_b2, wr_addr_x2, wr_addr_y2;
    logic [0:0] tw_addr2;

    fft_stage_sequencer #(.LOG2N(3), .MEM_LAT(1), .BFLY_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_addr(tw_addr), .wr_en(wr_en), .wr_addr_x(wr_addr_x), .wr_addr_y(wr_addr_y)
    );

    fft_stage_sequencer #(.LOG2N(2), .MEM_LAT(2), .BFLY_LAT(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .stage(stage2), .rd_en(rd_en2), .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2),
        .tw_addr(tw_addr2), .wr_en(wr_en2), .wr_addr_x(wr_addr_x2), .wr_addr_y(wr_addr_y2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Hand-derived read schedules.
    int exp_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int exp_a2 [4] = '{0, 2, 0, 1};
    int exp_b2 [4] = '{1, 3, 2, 3};
    int exp_tw2[4] = '{0, 0, 0, 1};

    typedef struct packed { logic v; logic [2:0] a; logic [2:0] b; } tup_t;
    typedef struct packed { logic v; logic [1:0] a; logic [1:0] b; } tup2_t;
    tup_t  hist  [1024];
    tup2_t hist2 [1024];
    int ridx  = 0;
    int ridx2 = 0;

    // Read schedule and write-back delay monitors.
    always @(negedge clk) begin
        if (!rst_n) begin
            ridx  = 0;
            ridx2 = 0;
            foreach (hist[i])  hist[i]  = '0;
            foreach (hist2[i]) hist2[i] = '0;
        end else begin
            if (cyc >= PL) begin
                check("wr_en_dly",  wr_en,     hist[(cyc-PL)%1024].v);
                check("wr_x_dly",   wr_addr_x, hist[(cyc-PL)%1024].a);
                check("wr_y_dly",   wr_addr_y, hist[(cyc-PL)%1024].b);
            end
            if (cyc >= PL2) begin
                check("wr_en2_dly", wr_en2,     hist2[(cyc-PL2)%1024].v);
                check("wr_x2_dly",  wr_addr_x2, hist2[(cyc-PL2)%1024].a);
                check("wr_y2_dly",  wr_addr_y2, hist2[(cyc-PL2)%1024].b);
            end
            hist[cyc%1024]  = '{rd_en,  rd_addr_a,  rd_addr_b};
            hist2[cyc%1024] = '{rd_en2, rd_addr_a2, rd_addr_b2};
            if (rd_en) begin
                check("rd_a",  rd_addr_a, exp_a[ridx]);
                check("rd_b",  rd_addr_b, exp_b[ridx]);
                check("rd_tw", tw_addr,   exp_tw[ridx]);
                ridx = (ridx + 1) % 12;
            end
            if (rd_en2) begin
                check("rd2_a",  rd_addr_a2, exp_a2[ridx2]);
                check("rd2_b",  rd_addr_b2, exp_b2[ridx2]);
                check("rd2_tw", tw_addr2,   exp_tw2[ridx2]);
                ridx2 = (ridx2 + 1) % 4;
            end
        end
    end

    // RAM (1-cycle read), twiddle ROM in Q1.14, and a 4-cycle butterfly.
    int tw_re[4] = '{16384, 11585, 0, -11585};
    int tw_im[4] = '{0, -11585, -16384, -11585};
    int src_re[8], src_im[8];
    int load_id = 0;
    int last_load = 0;
    int ram_re[8], ram_im[8];
    int s0_ar, s0_ai, s0_br, s0_bi, s0_wr, s0_wi;
    int bx_re[4], bx_im[4], by_re[4], by_im[4];

    always @(negedge clk) begin
        int pr, pi;
        if (load_id != last_load) begin
            last_load = load_id;
            for (int i = 0; i < 8; i++) begin
                ram_re[i] = src_re[i];
                ram_im[i] = src_im[i];
            end
        end
        if (wr_en) begin
            ram_re[wr_addr_x] = bx_re[3]; ram_im[wr_addr_x] = bx_im[3];
            ram_re[wr_addr_y] = by_re[3]; ram_im[wr_addr_y] = by_im[3];
        end
        for (int i = 3; i > 0; i--) begin
            bx_re[i] = bx_re[i-1]; bx_im[i] = bx_im[i-1];
            by_re[i] = by_re[i-1]; by_im[i] = by_im[i-1];
        end
        pr = (s0_br * s0_wr - s0_bi * s0_wi) >>> 14;
        pi = (s0_br * s0_wi + s0_bi * s0_wr) >>> 14;
        bx_re[0] = s0_ar + pr; bx_im[0] = s0_ai + pi;
        by_re[0] = s0_ar - pr; by_im[0] = s0_ai - pi;
        if (rd_en) begin
            s0_ar = ram_re[rd_addr_a]; s0_ai = ram_im[rd_addr_a];
            s0_br = ram_re[rd_addr_b]; s0_bi = ram_im[rd_addr_b];
            s0_wr = tw_re[tw_addr];    s0_wi = tw_im[tw_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start accepted in the current cycle c; checks cycles c+1 .. c+28.
    task automatic run_xform(input bit hold);
        start = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            tick;
            if (!hold) start = 1'b0;
            check("busy", busy, (i <= 27) ? 1 : 0);
            check("done", done, (i == 28) ? 1 : 0);
            if (i <= 27) check("stage", stage, (i - 1) / 9);
        end
    endtask

    int g_re[8], g_im[8];

    task automatic golden;
        int h, i, j, t, pr, pi, ar, ai;
        for (int n = 0; n < 8; n++) begin g_re[n] = src_re[n]; g_im[n] = src_im[n]; end
        for (int s = 0; s < 3; s++) begin
            h = 1 << s;
            for (int grp = 0; grp < 8; grp += 2 * h)
                for (int k = 0; k < h; k++) begin
                    i = grp + k; j = i + h; t = k * (8 / (2 * h));
                    pr = (g_re[j] * tw_re[t] - g_im[j] * tw_im[t]) >>> 14;
                    pi = (g_re[j] * tw_im[t] + g_im[j] * tw_re[t]) >>> 14;
                    ar = g_re[i]; ai = g_im[i];
                    g_re[i] = ar + pr; g_im[i] = ai + pi;
                    g_re[j] = ar - pr; g_im[j] = ai - pi;
                end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        repeat (3) tick;
        check("rst_busy", busy, 0);      check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);    check("rst_wr_en", wr_en, 0);
        check("rst_rd_a", rd_addr_a, 0); check("rst_rd_b", rd_addr_b, 0);
        check("rst_tw", tw_addr, 0);     check("rst_stage", stage, 0);
        check("rst_wr_x", wr_addr_x, 0); check("rst_wr_y", wr_addr_y, 0);
        check("rst2_busy", busy2, 0);    check("rst2_wr_en", wr_en2, 0);
        rst_n = 1'b1;
        tick;

        // Impulse: every bin must come out as 0x0100 + j0.
        for (int i = 0; i < 8; i++) begin src_re[i] = 0; src_im[i] = 0; end
        src_re[0] = 256;
        load_id++;
        tick;
        run_xform(1'b0);
        tick;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("imp_re[%0d]", i), ram_re[i], 256);
            check($sformatf("imp_im[%0d]", i), ram_im[i], 0);
        end

        // Random data, already laid out in bit-reversed order.
        for (int i = 0; i < 8; i++) begin
            src_re[i] = $signed($urandom_range(510)) - 255;
            src_im[i] = $signed($urandom_range(510)) - 255;
        end
        golden();
        load_id++;
        tick;
        run_xform(1'b0);
        tick;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rnd_re[%0d]", i), ram_re[i], g_re[i]);
            check($sformatf("rnd_im[%0d]", i), ram_im[i], g_im[i]);
        end

        // start held: ignored while running, re-accepted in the IDLE after DONE.
        run_xform(1'b1);
        tick;
        check("hold_idle_busy", busy, 0);
        check("hold_idle_done", done, 0);
        run_xform(1'b1);
        start = 1'b0;
        repeat (3) begin
            tick;
            check("hold_end_busy", busy, 0);
        end

        // Reset in the middle of stage 1 DRAIN.
        start = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick;
            start = 1'b0;
        end
        check("pre_rst_stage", stage, 1);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("mid_rst_busy", busy, 0);      check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_rd_en", rd_en, 0);    check("mid_rst_stage", stage, 0);
        check("mid_rst_rd_a", rd_addr_a, 0); check("mid_rst_rd_b", rd_addr_b, 0);
        check("mid_rst_tw", tw_addr, 0);     check("mid_rst_wr_x", wr_addr_x, 0);
        check("mid_rst_wr_y", wr_addr_y, 0); check("mid_rst_done", done, 0);
        repeat (6) begin
            tick;
            check("post_rst_wr_en", wr_en, 0);
            check("post_rst_busy", busy, 0);
        end
        run_xform(1'b0);
        tick;

        // LOG2N=2, MEM_LAT=2: done at c+17.
        start2 = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick;
            start2 = 1'b0;
            check("busy2", busy2, (i <= 16) ? 1 : 0);
            check("done2", done2, (i == 17) ? 1 : 0);
        end
        repeat (2) tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
